// File: rtl/mul_seq_ctrl_if.sv
// Handshake and operand bundle between the CPU control path and the
// iterative multiply sequencer. The CPU side is the master, the sequencer
// is the slave.
interface mul_seq_ctrl_if #(
   parameter int WIDTH = 32
);
   logic             start_i;
   logic [3:0]       alu_ctrl_i;
   logic [WIDTH-1:0] src1_i;
   logic [WIDTH-1:0] src2_i;
   logic             busy_o;
   logic             stall_o;
   logic             done_o;
   logic [WIDTH-1:0] result_o;

   modport master (
      output start_i, alu_ctrl_i, src1_i, src2_i,
      input  busy_o, stall_o, done_o, result_o
   );

   modport slave (
      input  start_i, alu_ctrl_i, src1_i, src2_i,
      output busy_o, stall_o, done_o, result_o
   );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Iterative shift-add MUL sequencer (ALU control 4'b0011).
// Produces one partial product per clock and stalls the CPU while it runs,
// then presents the low WIDTH bits of src1*src2 for one write-back cycle.
// Optional macro MUL_EARLY_TERM_EN: leave BUSY as soon as the remaining
// multiplier is zero.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start_i with alu_ctrl_i == MUL; operands loaded on go
// BUSY  | one shift-add step per edge; exits after WIDTH steps
// DONE  | one cycle, result_o valid for write-back, stall released
module mul_seq_ctrl #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic               clk_i,
   input  logic               rst_i,
   mul_seq_ctrl_if.slave      bus
);

   localparam logic [3:0]       ALU_MUL  = 4'b0011;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplr;
   logic             busy_r;
   logic             done_r;
   logic             go;

   // A run is requested only by a valid instruction carrying the MUL code.
   assign go = bus.start_i && (bus.alu_ctrl_i == ALU_MUL);

   // Sequencer state, datapath registers and registered status flags.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state  <= IDLE;
         cnt    <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplr   <= '0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done_r <= 1'b0;
               if (go) begin
                  mcand  <= bus.src1_i;
                  mplr   <= bus.src2_i;
                  acc    <= '0;
                  cnt    <= '0;
                  state  <= BUSY;
                  busy_r <= 1'b1;
               end
            end
            BUSY: begin
`ifdef MUL_EARLY_TERM_EN
               if (mplr == '0) begin
                  state  <= DONE;
                  busy_r <= 1'b0;
                  done_r <= 1'b1;
               end else
`endif
               begin
                  if (mplr[0]) begin
                     acc <= acc + mcand;
                  end
                  mcand <= {mcand[WIDTH-2:0], 1'b0};
                  mplr  <= {1'b0, mplr[WIDTH-1:1]};
                  cnt   <= cnt + CNT_W'(1);
                  if (cnt == CNT_LAST) begin
                     state  <= DONE;
                     busy_r <= 1'b0;
                     done_r <= 1'b1;
                  end
               end
            end
            DONE: begin
               // A go seen here is dropped; the CPU re-issues once stall falls.
               state  <= IDLE;
               done_r <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               busy_r <= 1'b0;
               done_r <= 1'b0;
            end
         endcase
      end
   end

   // Stall covers the issue cycle combinationally so the PC never advances
   // past the MUL; it drops in DONE so the write-back can proceed.
   assign bus.stall_o  = ((state == IDLE) && go) || (state == BUSY);
   assign bus.busy_o   = busy_r;
   assign bus.done_o   = done_r;
   assign bus.result_o = acc;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: directed vector table, random
// vectors against an arithmetic reference, and hand-written sequences for
// ignored restarts and mid-run reset.
module tb_mul_seq_ctrl;
   localparam int WIDTH = 32;

   logic clk_i = 1'b0;
   logic rst_i;
   int   checks   = 0;
   int   failures = 0;
   logic [WIDTH-1:0] exp_result;

   always #5 clk_i = ~clk_i;

   mul_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

   mul_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(6)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  ctrl;
      logic [31:0] exp;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Expected BUSY length from the multiplier value alone.
   function automatic int exp_busy(input logic [31:0] b);
`ifdef MUL_EARLY_TERM_EN
      int n = 0;
      for (int i = 0; i < WIDTH; i++) if (b[i]) n = i + 1;
      return (n + 1 < WIDTH) ? n + 1 : WIDTH;
`else
      return WIDTH;
`endif
   endfunction

   task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int inject_at);
      int cyc;
      @(negedge clk_i);
      bus.start_i    = 1'b1;
      bus.alu_ctrl_i = 4'b0011;
      bus.src1_i     = a;
      bus.src2_i     = b;
      #1 chk("issue_stall", 32'(bus.stall_o), 1);
      @(negedge clk_i);
      bus.start_i = 1'b0;
      bus.src1_i  = $urandom;
      bus.src2_i  = $urandom;
      cyc = 0;
      while (bus.busy_o === 1'b1 && cyc < 200) begin
         cyc++;
         if (cyc == inject_at) begin
            bus.start_i    = 1'b1;
            bus.alu_ctrl_i = 4'b0011;
            bus.src1_i     = $urandom;
            bus.src2_i     = $urandom;
         end
         #1 chk("busy_stall", 32'(bus.stall_o), 1);
         @(negedge clk_i);
         bus.start_i = 1'b0;
      end
      chk("busy_cycles", cyc, exp_busy(b));
      chk("done_pulse", 32'(bus.done_o), 1);
      chk("done_result", bus.result_o, exp);
      chk("done_stall", 32'(bus.stall_o), 0);
      exp_result = exp;
      // A go arriving during DONE must be dropped.
      bus.start_i    = 1'b1;
      bus.alu_ctrl_i = 4'b0011;
      #1 chk("done_go_stall", 32'(bus.stall_o), 0);
      @(negedge clk_i);
      bus.start_i = 1'b0;
      chk("after_done", 32'(bus.done_o), 0);
      chk("after_busy", 32'(bus.busy_o), 0);
      chk("held_result", bus.result_o, exp_result);
   endtask

   task automatic run_nonmul(input logic [3:0] ctrl);
      @(negedge clk_i);
      bus.start_i    = 1'b1;
      bus.alu_ctrl_i = ctrl;
      bus.src1_i     = $urandom;
      bus.src2_i     = $urandom;
      #1 chk("nonmul_stall", 32'(bus.stall_o), 0);
      @(negedge clk_i);
      bus.start_i = 1'b0;
      chk("nonmul_busy", 32'(bus.busy_o), 0);
      chk("nonmul_done", 32'(bus.done_o), 0);
      chk("nonmul_result", bus.result_o, exp_result);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[8];
      int   cyc;
      int   done_seen;
      logic [31:0] a, b;
      logic [3:0]  ctrl;

      vecs[0] = '{32'd7,          32'd6,          4'b0011, 32'd42};
      vecs[1] = '{32'd9,          32'd9,          4'b0010, 32'd42};
      vecs[2] = '{32'hFFFF_FFFF,  32'd3,          4'b0011, 32'hFFFF_FFFD};
      vecs[3] = '{32'h8000_0000,  32'd2,          4'b0011, 32'h0000_0000};
      vecs[4] = '{32'h0000_1234,  32'd5,          4'b0011, 32'h0000_5B04};
      vecs[5] = '{32'h0000_1234,  32'd0,          4'b0011, 32'h0000_0000};
      vecs[6] = '{32'h0000_1235,  32'h8000_0000,  4'b0011, 32'h8000_0000};
      vecs[7] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  4'b1011, 32'h8000_0000};

      rst_i          = 1'b1;
      bus.start_i    = 1'b0;
      bus.alu_ctrl_i = 4'b0000;
      bus.src1_i     = '0;
      bus.src2_i     = '0;
      exp_result     = '0;
      #2;
      chk("rst_busy",   32'(bus.busy_o), 0);
      chk("rst_done",   32'(bus.done_o), 0);
      chk("rst_stall",  32'(bus.stall_o), 0);
      chk("rst_result", bus.result_o, 0);
      @(negedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         chk("idle_stall", 32'(bus.stall_o), 0);
         chk("idle_busy",  32'(bus.busy_o), 0);
         chk("idle_done",  32'(bus.done_o), 0);
      end

      foreach (vecs[i]) begin
         if (vecs[i].ctrl == 4'b0011) run_mul(vecs[i].a, vecs[i].b, vecs[i].exp, 0);
         else                         run_nonmul(vecs[i].ctrl);
      end

      for (int i = 0; i < 12; i++) begin
         a = $urandom;
         b = $urandom >> $urandom_range(0, 31);
         ctrl = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0011;
         if (ctrl == 4'b0011) run_mul(a, b, a * b, 0);
         else                 run_nonmul(ctrl);
      end

      // Restart pulse with fresh operands mid-run must not disturb the product.
      a = 32'd9;
      b = 32'h8000_000B;
      run_mul(a, b, a * b, 10);

      // Reset in the middle of a run clears everything at once, no done_o.
      @(negedge clk_i);
      bus.start_i    = 1'b1;
      bus.alu_ctrl_i = 4'b0011;
      bus.src1_i     = 32'd13;
      bus.src2_i     = 32'h8000_0007;
      @(negedge clk_i);
      bus.start_i = 1'b0;
      cyc = 0;
      while (bus.busy_o === 1'b1 && cyc < 20) begin
         cyc++;
         if (cyc < 20) @(negedge clk_i);
      end
      chk("reached_cycle20", cyc, 20);
      rst_i = 1'b1;
      #1;
      chk("midrst_busy",   32'(bus.busy_o), 0);
      chk("midrst_done",   32'(bus.done_o), 0);
      chk("midrst_stall",  32'(bus.stall_o), 0);
      chk("midrst_result", bus.result_o, 0);
      @(negedge clk_i);
      rst_i = 1'b0;
      exp_result = '0;
      done_seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk_i);
         if (bus.done_o === 1'b1 || bus.busy_o === 1'b1) done_seen++;
      end
      chk("midrst_no_done", done_seen, 0);
      chk("midrst_result_hold", bus.result_o, exp_result);

      // Normal operation resumes after the reset.
      run_mul(32'd7, 32'd6, 32'd42, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Multi-cycle sequencer for the MUL operation (ALU control code 4'b0011) of the CPU datapath.
- Replaces the single-cycle multiply path with an iterative shift-add engine: one partial product per clock.
- Asserts a stall to the CPU while running, then presents the product for one write-back cycle.
- Sits beside the ALU, driven by the ALU control decoder output and the two ALU source operands.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  instruction-valid strobe from the control unit.
- alu_ctrl_i  in  4  ALU control code; a run starts only when this equals 4'b0011.
- src1_i  in  WIDTH  multiplicand.
- src2_i  in  WIDTH  multiplier.
- busy_o  out  1  high while in BUSY.
- stall_o  out  1  freeze request to the PC and pipeline registers.
- done_o  out  1  one-cycle pulse; result_o is valid in this cycle.
- result_o  out  WIDTH  low WIDTH bits of src1*src2.

Behaviour:
- States: IDLE, BUSY, DONE. A 2-bit register; the unused encoding recovers to IDLE on the next edge.
- Reset (asynchronous, any time, including mid-run): state=IDLE, counter=0, acc=0, mcand=0, mplr=0, busy_o=0, done_o=0, result_o=0, stall_o=0.
- go = start_i && (alu_ctrl_i == 4'b0011).
- IDLE:
  - If go: load mcand<=src1_i, mplr<=src2_i, acc<=0, cnt<=0, and go to BUSY.
  - If start_i is high with any other alu_ctrl_i: ignored.
- BUSY, each edge:
  - If mplr[0], acc<=acc+mcand (mod 2^WIDTH).
  - mcand<=mcand<<1; mplr<=mplr>>1 (logical); cnt<=cnt+1.
  - When cnt==WIDTH-1, the final step is performed and state goes to DONE.
  - start_i and alu_ctrl_i are ignored in BUSY; operands are sampled only at the IDLE->BUSY edge.
- DONE: lasts exactly one cycle, done_o=1, then returns to IDLE. A go sampled in DONE is ignored; the CPU re-issues only after the stall drops.
- result_o = acc. It is registered and held stable from DONE until the next IDLE->BUSY load.
- stall_o is combinational: (state==IDLE && go) || state==BUSY. It is low in DONE so the CPU advances and writes result_o.
- busy_o = (state==BUSY); done_o = (state==DONE). Both are decoded from registered state, so they are glitch-free.
- Latency without the optional feature:
  - go sampled at edge 0.
  - BUSY for WIDTH cycles.
  - done_o high in the cycle after edge WIDTH.
  - Total stall cycles = WIDTH+1 (includes the issue cycle).
- Arithmetic: only the low WIDTH bits are kept, so the result is identical for signed and unsigned operands. Overflow is silently discarded; there is no flag.

Optional Feature:
- Macro: MUL_EARLY_TERM_EN.
- Defined:
  - At each BUSY edge, if mplr==0, go directly to DONE with no add and no shift.
  - BUSY lasts n+1 cycles, where n = index of the highest set bit of src2_i plus 1.
  - src2_i==0 gives 1 BUSY cycle.
  - The cnt==WIDTH-1 exit still applies; when src2_i's MSB is set, the cnt exit is taken after WIDTH cycles and the mplr==0 check never fires.
- Undefined: fixed WIDTH-cycle BUSY regardless of operand values; no mplr==0 comparator is synthesised.

Test Plan:
- Reset then idle: rst_i pulse, start_i=0 -> all outputs 0, state IDLE, stall_o=0 throughout.
- Basic run: alu_ctrl_i=4'b0011, src1=7, src2=6, start_i 1 cycle -> stall_o high same cycle, busy_o 32 cycles, done_o one cycle with result_o=42, result_o holds 42 afterwards.
- Wrap and sign: src1=32'hFFFFFFFF (-1), src2=3 -> result_o=32'hFFFFFFFD; src1=32'h80000000, src2=2 -> result_o=0.
- Non-MUL start: start_i=1, alu_ctrl_i=4'b0010 -> no BUSY, stall_o=0, result_o unchanged.
- Mid-run reset and ignored restart: start a MUL, then pulse start_i with new operands at BUSY cycle 10 -> no effect on the result. Assert rst_i at BUSY cycle 20 -> all outputs 0 immediately, no done_o.
- MUL_EARLY_TERM_EN defined: src2=5 -> BUSY 4 cycles, result=5*src1; src2=0 -> BUSY 1 cycle, result 0; src2=32'h80000000 -> BUSY 32 cycles.
